// File: rtl/ifetch_resp_pkg.sv
// Shared fetch definitions: responder state encoding and the boot/NOP
// constants that the IFU and the fetch responder agree on.
package ifetch_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h00000013;
  localparam logic [63:0] RESET_ADDR = 64'h80000000;

endpackage

// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: turns the IFU pc into one outstanding 64-bit
// memory read and returns the selected 32-bit word, holding it across stalls.
module ifetch_resp
  import ifetch_resp_pkg::*;
#(
  parameter logic [63:0] RESET_ADDR = ifetch_resp_pkg::RESET_ADDR,
  parameter logic [31:0] NOP_INSTR  = ifetch_resp_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] pc,
  input  logic        jump_en,
  input  logic        hazard_stop,
  output logic        ifetch_en,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  fetch_state_e state;
  logic         kill;
  logic         sel;
  logic         pc_lo_unused;

  // Instructions are 4-byte aligned, so the two low pc bits carry no information.
  assign pc_lo_unused = ^pc[1:0];

  // The IFU may only advance once the address phase is accepted for a fetch
  // that is still wanted.
  assign ifetch_en = (state == REQ) && mem_gnt && !kill && !jump_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      kill        <= 1'b0;
      sel         <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_ADDR;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!jump_en) begin
            mem_req  <= 1'b1;
            mem_addr <= {pc[63:3], 3'b000};
            sel      <= pc[2];
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            kill    <= kill | jump_en;
            state   <= RESP;
          end else if (jump_en) begin
            kill <= 1'b1;
          end
        end
        RESP: begin
          // A redirect seen anywhere since the request makes the data stale.
          if (mem_rvalid) begin
            if (kill || jump_en) begin
              kill  <= 1'b0;
              state <= IDLE;
            end else begin
              instr       <= sel ? mem_rdata[63:32] : mem_rdata[31:0];
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end else if (jump_en) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (!hazard_stop || jump_en) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ifetch_resp.md
Name: ifetch_resp

Overview:
Instruction-fetch responder on the IFU's fetch interface. It consumes the IFU's pc, generates the ifetch_en advance pulse, and returns instr/instr_valid. Internally it bridges to a 64-bit instruction memory port with a req/gnt address phase and an rvalid data phase. It allows one outstanding request, cancels fetches on redirect (jump_en), and re-presents a delivered instruction while the pipeline stalls (hazard_stop).

Parameters:
RESET_ADDR, 64'h80000000, reset value of mem_addr; equals the core boot pc
NOP_INSTR, 32'h00000013, instr value when no valid instruction is presented

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
pc  input  64  IFU fetch pc
jump_en  input  1  redirect this cycle; in-flight fetch becomes stale
hazard_stop  input  1  pipeline stall; delivered instruction must be held
ifetch_en  output  1  pc consumed; IFU advances pc to pc+4 at this edge
instr  output  32  fetched instruction
instr_valid  output  1  instr valid for the IFU
mem_req  output  1  memory address-phase request
mem_addr  output  64  memory address, 8-byte aligned
mem_gnt  input  1  address phase accepted (when mem_req high)
mem_rvalid  input  1  read data valid
mem_rdata  input  64  read data

Behaviour:
- Reset (async, rstn low): state=IDLE, kill=0, mem_req=0, mem_addr=RESET_ADDR, instr=NOP_INSTR, instr_valid=0. Reset mid-transaction abandons the request; the memory side is reset by the same rstn.
- All outputs are registered except ifetch_en.
- ifetch_en = (state==REQ) & mem_gnt & !kill & !jump_en. It never coincides with instr_valid.
- IDLE:
  - If !jump_en: mem_req<=1, mem_addr<={pc[63:3],3'b0}, sel<=pc[2], go to REQ.
  - If jump_en: wait for the redirected pc.
- REQ:
  - mem_req and mem_addr are held stable until mem_gnt.
  - jump_en without gnt: kill<=1 (sticky).
  - On mem_gnt: mem_req<=0, kill<=kill|jump_en, go to RESP.
- RESP:
  - jump_en: kill<=1.
  - On mem_rvalid with (kill|jump_en): drop the data, kill<=0, go to IDLE; instr_valid stays 0.
  - On mem_rvalid otherwise: instr<=sel ? mem_rdata[63:32] : mem_rdata[31:0], instr_valid<=1, go to HOLD.
- HOLD (instr_valid=1):
  - hazard_stop & !jump_en: hold instr and instr_valid unchanged.
  - Otherwise (consumed, or redirect): instr_valid<=0, instr<=NOP_INSTR, go to IDLE.
- Minimum latency, with gnt in the first REQ cycle and rvalid on the next edge:
  - pc sampled at edge 0; mem_req high in cycle 1.
  - ifetch_en pulse in cycle 1; rvalid in cycle 2.
  - instr_valid high in cycle 3.
- Throughput: one instruction per 4 cycles minimum; the IDLE bubble is accepted.
- Simultaneous events:
  - jump_en and mem_gnt in the same cycle: ifetch_en=0, request is killed.
  - jump_en and mem_rvalid in the same cycle: data is dropped.
  - jump_en in HOLD: release without waiting for hazard_stop.
- mem_rvalid outside RESP and mem_gnt outside REQ are ignored (protocol violation; the bench asserts they never occur).

Decomposition:
- Shared fetch package: 2-bit state enum (IDLE, REQ, RESP, HOLD), NOP_INSTR, RESET_ADDR. The IFU also uses NOP_INSTR and RESET_ADDR.
- No sub-module; the FSM, kill flag and word select stay in one module.

Test Plan:
- Reset release, pc=0x80000000, gnt immediate, rvalid next cycle with rdata=0x00000297_00000413 -> mem_addr=0x80000000, ifetch_en single pulse in cycle 1, instr=0x00000413 and instr_valid=1 in cycle 3.
- pc=0x80000004 with the same rdata -> instr=0x00000297 (upper word selected).
- gnt delayed 3 cycles -> mem_req and mem_addr=0x80000000 stable all 3 cycles; exactly one ifetch_en pulse, on the gnt cycle.
- jump_en in RESP, then rvalid -> no instr_valid, kill cleared, next mem_addr taken from the new pc (e.g. 0x80001000).
- jump_en in REQ two cycles before gnt -> ifetch_en stays 0 at gnt, response dropped.
- hazard_stop held 5 cycles in HOLD -> instr and instr_valid=1 stable for all 5 cycles, no new mem_req; after release, instr_valid drops next cycle and IDLE issues.
- rstn asserted in RESP -> outputs go to reset values immediately (asynchronously); a later rvalid is ignored.
